// File: rtl/bsg_mul_pkg.sv
// Shared types for the multiply issue front end: opcodes, sequencer states
// and the opcode-to-multiplier-control decode.
package bsg_mul_pkg;

  typedef enum logic [1:0] {
    eMUL    = 2'b00,
    eMULH   = 2'b01,
    eMULHSU = 2'b10,
    eMULHU  = 2'b11
  } bsg_mul_op_e;

  typedef enum logic [1:0] {
    eIdle  = 2'b00,
    eIssue = 2'b01,
    eWait  = 2'b10,
    eDone  = 2'b11
  } bsg_mul_seq_state_e;

  typedef struct packed {
    logic signed_opA;
    logic signed_opB;
    logic gets_high_part;
  } bsg_mul_ctrl_s;

  // The low half of a product is identical for every signedness, so MUL
  // decodes to the unsigned form.
  function automatic bsg_mul_ctrl_s bsg_mul_decode(input bsg_mul_op_e op);
    bsg_mul_ctrl_s ctrl;
    ctrl = '0;
    unique case (op)
      eMUL:    ctrl = '{signed_opA: 1'b0, signed_opB: 1'b0, gets_high_part: 1'b0};
      eMULH:   ctrl = '{signed_opA: 1'b1, signed_opB: 1'b1, gets_high_part: 1'b1};
      eMULHSU: ctrl = '{signed_opA: 1'b1, signed_opB: 1'b0, gets_high_part: 1'b1};
      eMULHU:  ctrl = '{signed_opA: 1'b0, signed_opB: 1'b0, gets_high_part: 1'b1};
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/bsg_mul_op_decode.sv
// Combinational opcode decoder producing the multiplier's sign and
// high-part controls.
module bsg_mul_op_decode
  import bsg_mul_pkg::*;
(
  input  bsg_mul_op_e   op_i,
  output bsg_mul_ctrl_s ctrl_o
);

  assign ctrl_o = bsg_mul_decode(op_i);

endmodule

// File: rtl/bsg_mul_op_sequencer.sv
// Issue stage in front of bsg_imul_iterative: accepts one tagged multiply,
// drives the multiplier handshake and returns the buffered result.
module bsg_mul_op_sequencer
  import bsg_mul_pkg::*;
#(
  parameter int width_p       = 32,
  parameter int tag_width_p   = 4,
  parameter int zero_bypass_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [1:0]             op_i,
  input  logic [tag_width_p-1:0] tag_i,
  input  logic [width_p-1:0]     opA_i,
  input  logic [width_p-1:0]     opB_i,

  output logic                   v_o,
  output logic [width_p-1:0]     result_o,
  output logic [tag_width_p-1:0] tag_o,
  input  logic                   yumi_i,

  output logic                   mul_v_o,
  input  logic                   mul_ready_i,
  output logic [width_p-1:0]     mul_opA_o,
  output logic [width_p-1:0]     mul_opB_o,
  output logic                   mul_signed_opA_o,
  output logic                   mul_signed_opB_o,
  output logic                   mul_gets_high_part_o,
  input  logic                   mul_v_i,
  input  logic [width_p-1:0]     mul_result_i,
  output logic                   mul_yumi_o
);

  localparam bit bypass_en_lp = (zero_bypass_p != 0);

  bsg_mul_seq_state_e     state_r;
  bsg_mul_ctrl_s          ctrl_r;
  bsg_mul_ctrl_s          dec_ctrl;
  logic                   ready_r;
  logic                   v_r;
  logic                   mul_v_r;
  logic [width_p-1:0]     opA_r;
  logic [width_p-1:0]     opB_r;
  logic [width_p-1:0]     result_r;
  logic [tag_width_p-1:0] tag_r;
  logic                   accept;
  logic                   zero_operand;

  bsg_mul_op_decode u_decode (
    .op_i   (bsg_mul_op_e'(op_i)),
    .ctrl_o (dec_ctrl)
  );

  // ready_r mirrors (state_r == eIdle) but stays low through reset, so the
  // first accept can only happen after reset has been released.
  assign accept       = v_i & ready_r;
  assign zero_operand = (opA_i == '0) || (opB_i == '0);

  // NOTE: every register below is written with <= so all of them update from
  // the same pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= eIdle;
      ready_r  <= 1'b0;
      v_r      <= 1'b0;
      mul_v_r  <= 1'b0;
      ctrl_r   <= '0;
      opA_r    <= '0;
      opB_r    <= '0;
      result_r <= '0;
      tag_r    <= '0;
    end else begin
      unique case (state_r)
        eIdle: begin
          if (accept) begin
            ready_r <= 1'b0;
            opA_r   <= opA_i;
            opB_r   <= opB_i;
            tag_r   <= tag_i;
            ctrl_r  <= dec_ctrl;
            if (bypass_en_lp && zero_operand) begin
              result_r <= '0;
              v_r      <= 1'b1;
              state_r  <= eDone;
            end else begin
              mul_v_r <= 1'b1;
              state_r <= eIssue;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end

        eIssue: begin
          if (mul_ready_i) begin
            mul_v_r <= 1'b0;
            state_r <= eWait;
          end
        end

        eWait: begin
          if (mul_v_i) begin
            result_r <= mul_result_i;
            v_r      <= 1'b1;
            state_r  <= eDone;
          end
        end

        eDone: begin
          if (yumi_i) begin
            v_r     <= 1'b0;
            ready_r <= 1'b1;
            state_r <= eIdle;
          end
        end

        default: begin
          ready_r <= 1'b0;
          v_r     <= 1'b0;
          mul_v_r <= 1'b0;
          state_r <= eIdle;
        end
      endcase
    end
  end

  assign ready_o              = ready_r;
  assign v_o                  = v_r;
  assign result_o             = result_r;
  assign tag_o                = tag_r;
  assign mul_v_o              = mul_v_r;
  assign mul_opA_o            = opA_r;
  assign mul_opB_o            = opB_r;
  assign mul_signed_opA_o     = ctrl_r.signed_opA;
  assign mul_signed_opB_o     = ctrl_r.signed_opB;
  assign mul_gets_high_part_o = ctrl_r.gets_high_part;

  // A multiplier result outside eWait is never acknowledged.
  assign mul_yumi_o = (state_r == eWait) & mul_v_i;

endmodule

// File: tb/tb_bsg_mul_op_sequencer.sv
// Self-checking bench: a zero-bypass and a no-bypass sequencer, each with a
// behavioural iterative-multiplier stand-in, checked against an arithmetic model.
module tb_bsg_mul_op_sequencer;
  import bsg_mul_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic [1:0]    v_i, ready, v_o, yumi, mul_v_o, mul_ready, mul_v_i, mul_yumi;
  logic [1:0]    m_sa, m_sb, m_hi;
  logic [1:0]    op;
  logic [TW-1:0] tag_in;
  logic [W-1:0]  opA, opB;
  logic [W-1:0]  result [2];
  logic [TW-1:0] tag_out [2];
  logic [W-1:0]  m_opA [2];
  logic [W-1:0]  m_opB [2];
  logic [W-1:0]  m_res [2];

  bsg_mul_op_sequencer #(.width_p(W), .tag_width_p(TW), .zero_bypass_p(1)) dut_byp (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i[0]), .ready_o(ready[0]), .op_i(op), .tag_i(tag_in), .opA_i(opA), .opB_i(opB),
    .v_o(v_o[0]), .result_o(result[0]), .tag_o(tag_out[0]), .yumi_i(yumi[0]),
    .mul_v_o(mul_v_o[0]), .mul_ready_i(mul_ready[0]), .mul_opA_o(m_opA[0]), .mul_opB_o(m_opB[0]),
    .mul_signed_opA_o(m_sa[0]), .mul_signed_opB_o(m_sb[0]), .mul_gets_high_part_o(m_hi[0]),
    .mul_v_i(mul_v_i[0]), .mul_result_i(m_res[0]), .mul_yumi_o(mul_yumi[0])
  );

  bsg_mul_op_sequencer #(.width_p(W), .tag_width_p(TW), .zero_bypass_p(0)) dut_nobyp (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i[1]), .ready_o(ready[1]), .op_i(op), .tag_i(tag_in), .opA_i(opA), .opB_i(opB),
    .v_o(v_o[1]), .result_o(result[1]), .tag_o(tag_out[1]), .yumi_i(yumi[1]),
    .mul_v_o(mul_v_o[1]), .mul_ready_i(mul_ready[1]), .mul_opA_o(m_opA[1]), .mul_opB_o(m_opB[1]),
    .mul_signed_opA_o(m_sa[1]), .mul_signed_opB_o(m_sb[1]), .mul_gets_high_part_o(m_hi[1]),
    .mul_v_i(mul_v_i[1]), .mul_result_i(m_res[1]), .mul_yumi_o(mul_yumi[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result from opcode semantics: unsigned high half corrected for
  // the operands that are negative when read as signed.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] uu;
    logic [W-1:0]   hi_u;
    uu   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    hi_u = uu[2*W-1:W];
    case (o)
      2'd0:    return uu[W-1:0];
      2'd1:    return hi_u - (a[W-1] ? b : '0) - (b[W-1] ? a : '0);
      2'd2:    return hi_u - (a[W-1] ? b : '0);
      default: return hi_u;
    endcase
  endfunction

  // Expected {signed_opA, signed_opB, gets_high_part} per opcode.
  function automatic logic [2:0] exp_ctrl(input logic [1:0] o);
    case (o)
      2'd0:    return 3'b000;
      2'd1:    return 3'b111;
      2'd2:    return 3'b101;
      default: return 3'b001;
    endcase
  endfunction

  // Stand-in for bsg_imul_iterative: fixed latency, result from its controls.
  function automatic logic [W-1:0] imul(input logic sa, input logic sb, input logic hi,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, p;
    ea = {{W{sa & a[W-1]}}, a};
    eb = {{W{sb & b[W-1]}}, b};
    p  = ea * eb;
    return hi ? p[2*W-1:W] : p[W-1:0];
  endfunction

  logic [1:0] busy;
  int unsigned cnt [2];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset_i) begin
        busy[g]      <= 1'b0;
        mul_ready[g] <= 1'b1;
        mul_v_i[g]   <= 1'b0;
        m_res[g]     <= '0;
        cnt[g]       <= 0;
      end else if (!busy[g]) begin
        if (mul_v_o[g] && mul_ready[g]) begin
          busy[g]      <= 1'b1;
          mul_ready[g] <= 1'b0;
          cnt[g]       <= 3;
          m_res[g]     <= imul(m_sa[g], m_sb[g], m_hi[g], m_opA[g], m_opB[g]);
        end
      end else if (cnt[g] != 0) begin
        cnt[g] <= cnt[g] - 1;
        if (cnt[g] == 1) mul_v_i[g] <= 1'b1;
      end else if (mul_v_i[g] && mul_yumi[g]) begin
        mul_v_i[g]   <= 1'b0;
        busy[g]      <= 1'b0;
        mul_ready[g] <= 1'b1;
      end
    end
  end

  // Scoreboard: expected results queued at accept, retired on yumi.
  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_s;

  exp_s       q0 [$];
  exp_s       q1 [$];
  logic [1:0] inflight;
  logic       rst_last = 1'b1;

  always @(posedge clk) begin
    rst_last <= reset_i;
    if (reset_i) begin
      q0.delete();
      q1.delete();
      inflight <= '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (v_o[g] && yumi[g]) begin
          if (g == 0 && q0.size() > 0) void'(q0.pop_front());
          if (g == 1 && q1.size() > 0) void'(q1.pop_front());
          inflight[g] <= 1'b0;
        end
        if (v_i[g] && ready[g]) begin
          if (g == 0) q0.push_back('{res: model(op, opA, opB), tag: tag_in});
          else        q1.push_back('{res: model(op, opA, opB), tag: tag_in});
          inflight[g] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_last) begin
        check($sformatf("rst_ready[%0d]", g), ready[g], 1'b0);
        check($sformatf("rst_v_o[%0d]", g), v_o[g], 1'b0);
        check($sformatf("rst_mul_v_o[%0d]", g), mul_v_o[g], 1'b0);
        check($sformatf("rst_mul_yumi[%0d]", g), mul_yumi[g], 1'b0);
      end else begin
        check($sformatf("ready[%0d]", g), ready[g], !inflight[g]);
        if (!inflight[g]) begin
          check($sformatf("idle_v_o[%0d]", g), v_o[g], 1'b0);
          check($sformatf("idle_mul_v_o[%0d]", g), mul_v_o[g], 1'b0);
        end
        if (!mul_v_i[g]) check($sformatf("mul_yumi[%0d]", g), mul_yumi[g], 1'b0);
        if (v_o[g]) begin
          if ((g == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("spurious_v_o[%0d]", g), v_o[g], 1'b0);
          end else begin
            exp_s e;
            e = (g == 0) ? q0[0] : q1[0];
            check($sformatf("model_result[%0d]", g), result[g], e.res);
            check($sformatf("model_tag[%0d]", g), tag_out[g], e.tag);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int g, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] t);
    bit done;
    done   = 1'b0;
    op     = o;
    opA    = a;
    opB    = b;
    tag_in = t;
    v_i[g] = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      if (ready[g]) done = 1'b1;
    end
    check("accept_timeout", done, 1'b1);
    @(negedge clk);
    v_i[g] = 1'b0;
  endtask

  // Waits for v_o, checks it, optionally stalls with ignored v_i pulses, then takes it.
  task automatic take(input int g, input string name, input logic [W-1:0] exp_res,
                      input logic [TW-1:0] exp_tag, input int hold);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (v_o[g]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_valid"}, seen, 1'b1);
    if (seen) begin
      check({name, "_result"}, result[g], exp_res);
      check({name, "_tag"}, tag_out[g], exp_tag);
      for (int i = 0; i < hold; i++) begin
        v_i[g] = i[0];
        op     = eMULHU;
        opA    = $urandom;
        opB    = $urandom;
        tag_in = 4'hF;
        @(negedge clk);
        check({name, "_hold_v_o"}, v_o[g], 1'b1);
        check({name, "_hold_result"}, result[g], exp_res);
        check({name, "_hold_tag"}, tag_out[g], exp_tag);
        check({name, "_hold_ready"}, ready[g], 1'b0);
      end
      v_i[g]  = 1'b0;
      yumi[g] = 1'b1;
      @(negedge clk);
      yumi[g] = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]    o;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] t;
    logic [W-1:0]  r;
    string         name;
  } vec_s;

  vec_s vecs [5];

  initial begin
    vecs[0] = '{2'd0, 32'd3,         32'd5,         4'd2, 32'h0000_000F, "mul_3x5"};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'h0000_0000, "mulh_m1xm1"};
    vecs[2] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFE, "mulhu_max"};
    vecs[3] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 4'd6, 32'hFFFF_FFFF, "mulhsu_m1x2"};
    vecs[4] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 4'd7, 32'h4000_0000, "mulh_min"};

    reset_i = 1'b1;
    v_i     = '0;
    yumi    = '0;
    op      = '0;
    opA     = '0;
    opB     = '0;
    tag_in  = '0;
    repeat (3) @(negedge clk);

    check("reset_ready", ready[0], 1'b0);
    check("reset_result", result[0], '0);
    check("reset_tag", tag_out[0], '0);
    check("reset_mul_opA", m_opA[0], '0);
    check("reset_mul_opB", m_opB[0], '0);
    check("reset_ctrl", {m_sa[0], m_sb[0], m_hi[0]}, 3'b000);

    reset_i = 1'b0;
    @(negedge clk);
    check("post_reset_ready0", ready[0], 1'b1);
    check("post_reset_ready1", ready[1], 1'b1);

    check("pin_model_mul", model(eMUL, 32'd7, 32'd6), 32'd42);
    check("pin_model_mulh", model(eMULH, 32'hFFFF_FFFF, 32'h0000_0003), 32'hFFFF_FFFF);
    check("pin_model_mulhsu", model(eMULHSU, 32'h0000_0003, 32'hFFFF_FFFF), 32'h0000_0002);
    check("pin_model_mulhu", model(eMULHU, 32'h8000_0000, 32'h0000_0004), 32'h0000_0002);

    for (int k = 0; k < 5; k++) begin
      issue(0, vecs[k].o, vecs[k].a, vecs[k].b, vecs[k].t);
      check({vecs[k].name, "_mul_v_o"}, mul_v_o[0], 1'b1);
      check({vecs[k].name, "_ctrl"}, {m_sa[0], m_sb[0], m_hi[0]}, exp_ctrl(vecs[k].o));
      check({vecs[k].name, "_mul_opA"}, m_opA[0], vecs[k].a);
      check({vecs[k].name, "_mul_opB"}, m_opB[0], vecs[k].b);
      take(0, vecs[k].name, vecs[k].r, vecs[k].t, 0);
    end

    // Zero bypass: result in the cycle after accept, multiplier untouched.
    issue(0, eMUL, 32'd0, 32'h0000_1234, 4'd5);
    check("bypass_v_o", v_o[0], 1'b1);
    check("bypass_mul_v_o", mul_v_o[0], 1'b0);
    take(0, "bypass_a0", 32'd0, 4'd5, 0);
    check("bypass_mul_v_o_after", mul_v_o[0], 1'b0);

    issue(0, eMULHU, 32'hDEAD_BEEF, 32'd0, 4'd8);
    check("bypass_b0_v_o", v_o[0], 1'b1);
    check("bypass_b0_mul_v_o", mul_v_o[0], 1'b0);
    take(0, "bypass_b0", 32'd0, 4'd8, 0);

    // Same zero request without bypass goes through the multiplier.
    issue(1, eMUL, 32'd0, 32'h0000_1234, 4'd5);
    check("nobypass_v_o", v_o[1], 1'b0);
    check("nobypass_mul_v_o", mul_v_o[1], 1'b1);
    take(1, "nobypass", 32'd0, 4'd5, 0);

    issue(1, eMULH, 32'hFFFF_FFFE, 32'h0000_0003, 4'd1);
    take(1, "nobypass_mulh", 32'hFFFF_FFFF, 4'd1, 0);

    // Backpressure: ten stalled cycles with ignored v_i pulses.
    issue(0, eMUL, 32'd7, 32'd9, 4'd9);
    take(0, "backpressure", 32'd63, 4'd9, 10);

    // Reset while waiting on the multiplier.
    issue(0, eMULHU, 32'h1234_5678, 32'h9ABC_DEF0, 4'hA);
    check("ewait_entry_mul_v_o", mul_v_o[0], 1'b1);
    @(negedge clk);
    check("ewait_mul_v_o", mul_v_o[0], 1'b0);
    check("ewait_v_o", v_o[0], 1'b0);
    reset_i = 1'b1;
    @(negedge clk);
    check("midreset_v_o", v_o[0], 1'b0);
    check("midreset_mul_v_o", mul_v_o[0], 1'b0);
    check("midreset_mul_yumi", mul_yumi[0], 1'b0);
    check("midreset_result", result[0], '0);
    check("midreset_tag", tag_out[0], '0);
    reset_i = 1'b0;
    @(negedge clk);
    check("after_midreset_ready", ready[0], 1'b1);
    issue(0, eMUL, 32'd7, 32'd6, 4'd1);
    take(0, "after_reset_mul", 32'd42, 4'd1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
